// File: rtl/inst_mem_sync.sv
// inst_mem_sync: synchronous-read instruction memory for the IF stage, cleared on reset and
// loaded at run time through a streaming port. Optional parity storage: `define INST_MEM_PARITY_EN.
module inst_mem_sync #(
   parameter int                DATA_W = 32,
   parameter int                ADDR_W = 6,
   parameter logic [DATA_W-1:0] NOP    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] inst,
   output logic              inst_valid,
   output logic              busy,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              par_err,
   output logic [1:0]        state
);

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   localparam logic [1:0] S_CLEAR = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;

`ifdef INST_MEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [MEM_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wptr;
   logic              run;
   logic              beat;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic [MEM_W-1:0]  wr_word;
   logic [MEM_W-1:0]  rd_word;

   // Load handshake: ld_ready is high on every LOAD cycle and only then; one word transfers on each
   // cycle with ld_valid && ld_ready. The source holds ld_data/ld_last stable while ld_valid waits.
   assign run      = (state == S_RUN);
   assign busy     = !run;
   assign ld_ready = (state == S_LOAD);
   assign beat     = ld_valid && ld_ready;
   assign wr_en    = (state == S_CLEAR) || beat;
   assign wr_data  = (state == S_CLEAR) ? NOP : ld_data;

`ifdef INST_MEM_PARITY_EN
   assign wr_word = {^wr_data, wr_data};
`else
   assign wr_word = wr_data;
`endif

   assign rd_word = mem[addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_CLEAR;
         wptr  <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               if (wptr == LAST_ADDR) begin
                  state <= S_RUN;
                  wptr  <= '0;
               end else begin
                  wptr <= wptr + 1'b1;
               end
            end
            S_RUN: begin
               if (ld_start) begin
                  state <= S_LOAD;
                  wptr  <= '0;
               end
            end
            S_LOAD: begin
               // A full memory ends the load even without ld_last, so no beat can wrap to word 0.
               if (beat) begin
                  if (ld_last || (wptr == LAST_ADDR)) begin
                     state <= S_RUN;
                     wptr  <= '0;
                  end else begin
                     wptr <= wptr + 1'b1;
                  end
               end
            end
            default: begin
               state <= S_CLEAR;
               wptr  <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wptr] <= wr_word;
      end
   end

   // Flush outranks stall; outside RUN the fetch controls are ignored.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         inst       <= NOP;
         inst_valid <= 1'b0;
      end else if (flush) begin
         inst       <= NOP;
         inst_valid <= 1'b0;
      end else if (stall) begin
         inst       <= inst;
         inst_valid <= inst_valid;
      end else if (fetch_en) begin
         inst       <= rd_word[DATA_W-1:0];
         inst_valid <= 1'b1;
      end else begin
         inst       <= NOP;
         inst_valid <= 1'b0;
      end
   end

`ifdef INST_MEM_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst || !run || flush) begin
         par_err <= 1'b0;
      end else if (stall) begin
         par_err <= par_err;
      end else if (fetch_en) begin
         par_err <= (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
      end else begin
         par_err <= 1'b0;
      end
   end
`else
   assign par_err = 1'b0;
`endif

endmodule
